// File: rtl/wb_intc_pkg.sv
// Shared constants for the wb_intc interrupt controller: register word
// offsets (wb_adr_i[4:2]) and fixed bit positions in CTRL and VECTOR.
package wb_intc_pkg;

  typedef enum logic [2:0] {
    INTC_PENDING = 3'd0,
    INTC_ENABLE  = 3'd1,
    INTC_EDGE    = 3'd2,
    INTC_ACK     = 3'd3,
    INTC_VECTOR  = 3'd4,
    INTC_POL     = 3'd5,
    INTC_CTRL    = 3'd6,
    INTC_UNMAP   = 3'd7
  } intc_reg_e;

  localparam int CTRL_GEN_EN  = 0;
  localparam int VECTOR_VALID = 31;

endpackage

// File: rtl/intc_src.sv
// One interrupt source front end: multi-stage synchroniser, polarity
// correction and rising-edge detect on the corrected level.
module intc_src #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic src_i,
  input  logic pol_i,
  output logic level_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   act_q, act_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], src_i};
    act_d  = sync_q[SYNC_STAGES-1] ^ pol_i;
  end

  assign level_o = act_d;
  assign rise_o  = act_d & ~act_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      act_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      act_q  <= act_d;
    end
  end

endmodule

// File: rtl/wb_intc.sv
// Wishbone-slave interrupt controller: per-source level/edge latching,
// masking, lowest-index-first priority vector and registered irq outputs.
module wb_intc
  import wb_intc_pkg::*;
#(
  parameter int NUM_SRC     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wb_stb_i,
  input  logic               wb_cyc_i,
  input  logic               wb_we_i,
  input  logic [31:0]        wb_adr_i,
  input  logic [3:0]         wb_sel_i,
  input  logic [31:0]        wb_dat_i,
  output logic [31:0]        wb_dat_o,
  output logic               wb_ack_o,
  input  logic [NUM_SRC-1:0] src_i,
  output logic [NUM_SRC-1:0] irq_n_o,
  output logic               irq_o
);

  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] edge_sel_q, edge_sel_d;
  logic [NUM_SRC-1:0] pol_q, pol_d;
  logic               ctrl_q, ctrl_d;
  logic               ack_q, ack_d;
  logic [31:0]        dat_q, dat_d;
  logic [NUM_SRC-1:0] irq_n_q, irq_n_d;
  logic               irq_q, irq_d;

  logic [NUM_SRC-1:0] src_lvl, src_rise, req, ack_clr, wr_data;
  logic               access, wr_en;
  intc_reg_e          reg_sel;
  logic [31:0]        vector, rd_data;
  logic               unused_bits;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    intc_src #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_src (
      .clk    (clk),
      .rst    (rst),
      .src_i  (src_i[g]),
      .pol_i  (pol_q[g]),
      .level_o(src_lvl[g]),
      .rise_o (src_rise[g])
    );
  end

  // A new access is taken only while ack is low, giving one ack per strobe.
  assign access      = wb_stb_i & wb_cyc_i & ~ack_q;
  assign wr_en       = access & wb_we_i;
  assign reg_sel     = intc_reg_e'(wb_adr_i[4:2]);
  assign wr_data     = wb_dat_i[NUM_SRC-1:0];
  assign req         = pending_q & enable_q & {NUM_SRC{ctrl_q}};
  assign unused_bits = ^{wb_sel_i, wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i};

  function automatic logic [4:0] lowest_set(input logic [NUM_SRC-1:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

  always_comb begin
    vector               = '0;
    vector[VECTOR_VALID] = |req;
    vector[4:0]          = lowest_set(req);
  end

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      INTC_PENDING: rd_data[NUM_SRC-1:0] = pending_q;
      INTC_ENABLE:  rd_data[NUM_SRC-1:0] = enable_q;
      INTC_EDGE:    rd_data[NUM_SRC-1:0] = edge_sel_q;
      INTC_VECTOR:  rd_data              = vector;
      INTC_POL:     rd_data[NUM_SRC-1:0] = pol_q;
      INTC_CTRL:    rd_data[CTRL_GEN_EN] = ctrl_q;
      default:      rd_data              = '0;
    endcase
  end

  always_comb begin
    enable_d   = enable_q;
    edge_sel_d = edge_sel_q;
    pol_d      = pol_q;
    ctrl_d     = ctrl_q;
    ack_clr    = '0;
    if (wr_en) begin
      case (reg_sel)
        INTC_ENABLE: enable_d   = wr_data;
        INTC_EDGE:   edge_sel_d = wr_data;
        INTC_ACK:    ack_clr    = wr_data;
        INTC_POL:    pol_d      = wr_data;
        INTC_CTRL:   ctrl_d     = wb_dat_i[CTRL_GEN_EN];
        default:     ;
      endcase
    end
  end

  // Edge bits: a new rising edge beats a simultaneous ACK clear.
  // Level bits simply track the corrected source and ignore ACK.
  always_comb begin
    pending_d = (edge_sel_q & (src_rise | (pending_q & ~ack_clr)))
              | (~edge_sel_q & src_lvl);
    ack_d     = access;
    dat_d     = access ? rd_data : dat_q;
    irq_n_d   = ~req;
    irq_d     = |req;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q  <= '0;
      enable_q   <= '0;
      edge_sel_q <= '0;
      pol_q      <= '0;
      ctrl_q     <= 1'b0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
      irq_n_q    <= '1;
      irq_q      <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      enable_q   <= enable_d;
      edge_sel_q <= edge_sel_d;
      pol_q      <= pol_d;
      ctrl_q     <= ctrl_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      irq_n_q    <= irq_n_d;
      irq_q      <= irq_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign irq_n_o  = irq_n_q;
  assign irq_o    = irq_q;

endmodule

// File: tb/tb_wb_intc.sv
// Directed bench for wb_intc: bus reads push expected data into a
// scoreboard that a monitor drains on every ack; irq pins are checked inline.
module tb_wb_intc;

  localparam int          NUM_SRC = 8;
  localparam logic [31:0] BASE    = 32'h7000_0000;
  localparam logic [31:0] A_PEND  = BASE + 32'h00;
  localparam logic [31:0] A_EN    = BASE + 32'h04;
  localparam logic [31:0] A_EDGE  = BASE + 32'h08;
  localparam logic [31:0] A_ACK   = BASE + 32'h0C;
  localparam logic [31:0] A_VEC   = BASE + 32'h10;
  localparam logic [31:0] A_POL   = BASE + 32'h14;
  localparam logic [31:0] A_CTRL  = BASE + 32'h18;
  localparam logic [31:0] A_UNM   = BASE + 32'h1C;

  logic               clk = 1'b0;
  logic               rst;
  logic               wb_stb_i, wb_cyc_i, wb_we_i;
  logic [31:0]        wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]         wb_sel_i;
  logic               wb_ack_o;
  logic [NUM_SRC-1:0] src_i, irq_n_o;
  logic               irq_o;

  typedef struct {
    bit          chk;
    logic [31:0] exp;
    logic [31:0] adr;
  } sb_item_t;

  sb_item_t sb_q[$];
  sb_item_t sb_e;
  int       checks = 0;
  int       errors = 0;

  always #5 clk = ~clk;

  wb_intc #(
    .NUM_SRC(NUM_SRC),
    .SYNC_STAGES(2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wb_stb_i(wb_stb_i),
    .wb_cyc_i(wb_cyc_i),
    .wb_we_i (wb_we_i),
    .wb_adr_i(wb_adr_i),
    .wb_sel_i(wb_sel_i),
    .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o),
    .src_i   (src_i),
    .irq_n_o (irq_n_o),
    .irq_o   (irq_o)
  );

  // Monitor: every ack consumes one scoreboard entry; reads are compared.
  always @(negedge clk) begin
    if (rst && wb_ack_o) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_ack: got ack with empty scoreboard, required none");
      end else begin
        sb_e = sb_q.pop_front();
        if (sb_e.chk) begin
          checks++;
          if (wb_dat_o !== sb_e.exp) begin
            errors++;
            $display("[TB] FAIL read@%08h: got 0x%08h, required 0x%08h",
                     sb_e.adr, wb_dat_o, sb_e.exp);
          end
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
    end
  endtask

  task automatic wb_access(input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input bit chk,
                           input logic [31:0] exp);
    int       n;
    sb_item_t it;
    @(posedge clk);
    #1;
    wb_stb_i = 1'b1;
    wb_cyc_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = adr;
    wb_dat_i = dat;
    it.chk   = chk;
    it.exp   = exp;
    it.adr   = adr;
    sb_q.push_back(it);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!wb_ack_o && n < 8);
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_we_i  = 1'b0;
    if (!wb_ack_o) begin
      checks++;
      errors++;
      $display("[TB] FAIL ack_timeout@%08h: got no ack in %0d cycles, required ack", adr, n);
      it = sb_q.pop_back();
    end
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
    wb_access(1'b1, adr, dat, 1'b0, 32'h0);
  endtask

  task automatic wb_read(input logic [31:0] adr, input logic [31:0] exp);
    wb_access(1'b0, adr, 32'h0, 1'b1, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, required $finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst      = 1'b0;
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_we_i  = 1'b0;
    wb_adr_i = '0;
    wb_dat_i = '0;
    wb_sel_i = 4'hF;
    src_i    = '0;

    // Reset defaults
    cycles(4);
    check_output("rst_irq_n", 32'(irq_n_o), 32'hFF);
    check_output("rst_ack", 32'(wb_ack_o), 32'h0);
    rst = 1'b1;
    cycles(2);
    wb_read(A_PEND, 32'h0);
    wb_read(A_EN,   32'h0);
    wb_read(A_EDGE, 32'h0);
    wb_read(A_ACK,  32'h0);
    wb_read(A_VEC,  32'h0);
    wb_read(A_POL,  32'h0);
    wb_read(A_CTRL, 32'h0);
    check_output("dflt_irq_n", 32'(irq_n_o), 32'hFF);
    check_output("dflt_irq", 32'(irq_o), 32'h0);

    // Edge capture with exact 3-cycle latency, then ACK
    wb_write(A_EN,   32'h04);
    wb_write(A_EDGE, 32'h04);
    wb_write(A_CTRL, 32'h01);
    @(posedge clk); #1; src_i[2] = 1'b1;
    @(posedge clk); #1; src_i[2] = 1'b0;
    cycles(2);
    check_output("edge_lat_early", 32'(irq_n_o), 32'hFF);
    cycles(1);
    check_output("edge_lat_irq_n", 32'(irq_n_o), 32'hFB);
    check_output("edge_lat_irq", 32'(irq_o), 32'h1);
    wb_read(A_PEND, 32'h04);
    wb_read(A_VEC,  32'h8000_0002);
    wb_write(A_ACK, 32'h04);
    cycles(1);
    check_output("edge_ack_irq_n", 32'(irq_n_o), 32'hFF);
    wb_read(A_PEND, 32'h0);

    // Level mode: ACK ignored, deassert latency
    wb_write(A_EDGE, 32'h00);
    wb_write(A_EN,   32'h01);
    @(posedge clk); #1; src_i[0] = 1'b1;
    cycles(5);
    check_output("lvl_irq_n", 32'(irq_n_o), 32'hFE);
    wb_read(A_PEND, 32'h01);
    wb_write(A_ACK, 32'h01);
    wb_read(A_PEND, 32'h01);
    @(posedge clk); #1; src_i[0] = 1'b0;
    cycles(3);
    check_output("lvl_drop_early", 32'(irq_n_o), 32'hFE);
    cycles(1);
    check_output("lvl_drop_irq_n", 32'(irq_n_o), 32'hFF);

    // Priority and masking
    wb_write(A_EDGE, 32'h28);
    wb_write(A_EN,   32'h20);
    @(posedge clk); #1; src_i = 8'h28;
    @(posedge clk); #1; src_i = 8'h00;
    cycles(4);
    check_output("prio_irq_n5", 32'(irq_n_o), 32'hDF);
    wb_read(A_VEC, 32'h8000_0005);
    wb_write(A_EN, 32'h28);
    wb_read(A_VEC, 32'h8000_0003);
    check_output("prio_irq_n35", 32'(irq_n_o), 32'hD7);
    wb_write(A_CTRL, 32'h0);
    wb_read(A_VEC, 32'h0);
    check_output("gen_off_irq", 32'(irq_o), 32'h0);
    check_output("gen_off_irq_n", 32'(irq_n_o), 32'hFF);
    wb_read(A_PEND, 32'h28);

    // Set/clear collision on bit 1: the rising edge must win
    wb_write(A_ACK,  32'h28);
    wb_write(A_CTRL, 32'h01);
    wb_write(A_EDGE, 32'h2A);
    wb_write(A_EN,   32'h02);
    wb_read(A_PEND, 32'h0);
    @(posedge clk); #1; src_i[1] = 1'b1;
    @(posedge clk); #1;
    wb_write(A_ACK, 32'h02);
    wb_read(A_PEND, 32'h02);
    check_output("coll_irq_n", 32'(irq_n_o), 32'hFD);
    src_i[1] = 1'b0;

    // Readback widths, polarity inversion, unmapped offset
    wb_read(A_EDGE, 32'h2A);
    wb_read(A_CTRL, 32'h01);
    wb_write(A_POL, 32'hFFFF_FF40);
    cycles(2);
    wb_read(A_POL,  32'h40);
    wb_read(A_PEND, 32'h42);
    wb_write(A_POL, 32'h0);
    cycles(2);
    wb_read(A_PEND, 32'h02);
    wb_write(A_UNM, 32'hFFFF_FFFF);
    wb_read(A_UNM, 32'h0);
    wb_write(A_EN, 32'hFFFF_FF02);
    wb_read(A_EN, 32'h02);

    // Reset in the middle of a write while an irq is pending
    check_output("pre_rst_irq_n", 32'(irq_n_o), 32'hFD);
    @(posedge clk); #1;
    wb_stb_i = 1'b1;
    wb_cyc_i = 1'b1;
    wb_we_i  = 1'b1;
    wb_adr_i = A_EN;
    wb_dat_i = 32'hFF;
    #2 rst = 1'b0;
    #1;
    check_output("async_rst_irq_n", 32'(irq_n_o), 32'hFF);
    check_output("async_rst_irq", 32'(irq_o), 32'h0);
    @(posedge clk); #1;
    check_output("rst_no_ack", 32'(wb_ack_o), 32'h0);
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_we_i  = 1'b0;
    cycles(2);
    rst = 1'b1;
    cycles(2);
    wb_read(A_EN,   32'h0);
    wb_read(A_PEND, 32'h0);
    wb_read(A_CTRL, 32'h0);
    check_output("post_rst_irq_n", 32'(irq_n_o), 32'hFF);

    cycles(2);
    check_output("sb_drain", 32'(sb_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
